csr_unit: RTL and testbench

Machine-mode CSR unit; successor to the four-register CSR file, with set/clear access, trap entry/return sequencing, interrupt arbitration and parametrised performance counters. Sits beside the decode/execute stage: serves Zicsr reads/writes, records exceptions and interrupts, and supplies the redirect PC for trap entry and `mret`.

---
 rtl/csr_pkg.sv | 46 ++++
 rtl/csr_counter.sv | 37 +++
 rtl/csr_unit.sv | 178 +++++++++++++++++
 tb/tb_csr_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, access ops,
// interrupt cause codes and mstatus/mip bit positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } csr_op_e;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  // Reserved op yields the old value, so callers can treat it as "no change".
  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                            input logic [31:0] wdata);
    case (op)
      OP_WRITE: return wdata;
      OP_SET:   return old | wdata;
      OP_CLEAR: return old & ~wdata;
      default:  return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// CNT_W-bit free-running counter with increment enable and 32-bit half writes.
// Bits above CNT_W read as zero and ignore writes; a half write suppresses the increment.
module csr_counter
#(
  parameter int CNT_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] val
);

  logic [CNT_W-1:0] cnt;
  logic [63:0]      nxt;

  always_comb begin
    val = '0;
    val[CNT_W-1:0] = cnt;
    nxt = val;
    if (wr_lo) nxt[31:0] = wdata;
    if (wr_hi) nxt[63:32] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wr_lo || wr_hi) begin
      cnt <= nxt[CNT_W-1:0];
    end else if (inc) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: Zicsr access, trap entry/mret sequencing, interrupt arbitration
// and cycle/instret counters. Define CSR_VECTORED_EN for vectored mtvec mode.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          HART_ID   = 0,
  parameter int          CNT_W     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_rd,
  input  logic        csr_wr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] pc,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic        mret,
  input  logic        inst_ret,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  output logic [31:0] rdata,
  output logic        illegal,
  output logic        trap_take,
  output logic [31:0] trap_vec,
  output logic [31:0] epc
);

  logic        st_mie, st_mpie;
  logic        ie_ext, ie_sw, ie_tmr;
  logic        ip_ext, ip_sw, ip_tmr;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] mcycle_v, minstret_v;

  logic [31:0] rd_val, wval, trap_cause, tvec_base;
  logic        mapped, read_only, wr_en;
  logic        pend_ext, pend_sw, pend_tmr, irq_pend;
  logic [3:0]  irq_code;

  // MODE is kept as 0/1 only; in the non-vectored build it is forced to 0.
  function automatic logic [31:0] tvec_norm(input logic [31:0] v);
`ifdef CSR_VECTORED_EN
    return {v[31:2], 1'b0, (v[1:0] == 2'b01)};
`else
    return {v[31:2], 2'b00};
`endif
  endfunction

  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: begin
        rd_val[MSTATUS_MIE]  = st_mie;
        rd_val[MSTATUS_MPIE] = st_mpie;
      end
      CSR_MIE: begin
        rd_val[MIP_MEIP] = ie_ext;
        rd_val[MIP_MTIP] = ie_tmr;
        rd_val[MIP_MSIP] = ie_sw;
      end
      CSR_MTVEC:     rd_val = mtvec_q;
      CSR_MSCRATCH:  rd_val = mscratch_q;
      CSR_MEPC:      rd_val = mepc_q;
      CSR_MCAUSE:    rd_val = mcause_q;
      CSR_MIP: begin
        rd_val[MIP_MEIP] = ip_ext;
        rd_val[MIP_MTIP] = ip_tmr;
        rd_val[MIP_MSIP] = ip_sw;
      end
      CSR_MCYCLE:    rd_val = mcycle_v[31:0];
      CSR_MCYCLEH:   rd_val = mcycle_v[63:32];
      CSR_MINSTRET:  rd_val = minstret_v[31:0];
      CSR_MINSTRETH: rd_val = minstret_v[63:32];
      CSR_MHARTID:   rd_val = 32'(HART_ID);
      default:       mapped = 1'b0;
    endcase
  end

  assign read_only = (csr_addr == CSR_MIP) || (csr_addr == CSR_MHARTID);
  assign illegal   = ((csr_rd || csr_wr) && !mapped) || (csr_wr && read_only);
  assign rdata     = rd_val;
  assign wval      = csr_apply(csr_op_e'(csr_op), rd_val, csr_wdata);

  // Fixed arbitration: external beats software beats timer.
  assign pend_ext  = ip_ext & ie_ext;
  assign pend_sw   = ip_sw  & ie_sw;
  assign pend_tmr  = ip_tmr & ie_tmr;
  assign irq_pend  = st_mie & (pend_ext | pend_sw | pend_tmr);
  assign irq_code  = pend_ext ? CAUSE_MEI : (pend_sw ? CAUSE_MSI : CAUSE_MTI);

  assign trap_take  = exc_valid | irq_pend;
  assign trap_cause = exc_valid ? {28'b0, exc_cause} : {1'b1, 27'b0, irq_code};

  // A trap or an mret in the same cycle takes precedence over the CSR write.
  assign wr_en = csr_wr && !illegal && (csr_op != OP_RSVD) && !trap_take && !mret;

  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign epc       = mepc_q;

`ifdef CSR_VECTORED_EN
  assign trap_vec = (irq_pend && !exc_valid && (mtvec_q[1:0] == 2'b01))
                    ? tvec_base + {26'b0, irq_code, 2'b00} : tvec_base;
`else
  assign trap_vec = tvec_base;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      ie_ext     <= 1'b0;
      ie_sw      <= 1'b0;
      ie_tmr     <= 1'b0;
      ip_ext     <= 1'b0;
      ip_sw      <= 1'b0;
      ip_tmr     <= 1'b0;
      mtvec_q    <= tvec_norm(RESET_VEC);
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      ip_ext <= irq_ext;
      ip_sw  <= irq_sw;
      ip_tmr <= irq_timer;
      if (trap_take) begin
        mepc_q   <= pc & 32'hFFFF_FFFC;
        mcause_q <= trap_cause;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr_en) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            st_mie  <= wval[MSTATUS_MIE];
            st_mpie <= wval[MSTATUS_MPIE];
          end
          CSR_MIE: begin
            ie_ext <= wval[MIP_MEIP];
            ie_tmr <= wval[MIP_MTIP];
            ie_sw  <= wval[MIP_MSIP];
          end
          CSR_MTVEC:    mtvec_q    <= tvec_norm(wval);
          CSR_MSCRATCH: mscratch_q <= wval;
          CSR_MEPC:     mepc_q     <= wval & 32'hFFFF_FFFC;
          CSR_MCAUSE:   mcause_q   <= wval;
          default: ;
        endcase
      end
    end
  end

  csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (wr_en && (csr_addr == CSR_MCYCLE)),
    .wr_hi (wr_en && (csr_addr == CSR_MCYCLEH)),
    .wdata (wval),
    .val   (mcycle_v)
  );

  csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (inst_ret),
    .wr_lo (wr_en && (csr_addr == CSR_MINSTRET)),
    .wr_hi (wr_en && (csr_addr == CSR_MINSTRETH)),
    .wdata (wval),
    .val   (minstret_v)
  );

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: constant vector table, directed trap/counter
// sequences and randomized traffic checked against a word-level CSR model.
module tb_csr_unit;

  localparam logic [31:0] RV  = 32'h0000_1000;
  localparam int          HID = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_rd, csr_wr;
  logic [1:0]  csr_op;
  logic [31:0] pc;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic        mret, inst_ret;
  logic        irq_ext, irq_sw, irq_timer;
  logic [31:0] rdata;
  logic        illegal, trap_take;
  logic [31:0] trap_vec, epc;

  always #5 clk = ~clk;

  csr_unit #(.RESET_VEC(RV), .HART_ID(HID), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_op(csr_op), .pc(pc),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .mret(mret), .inst_ret(inst_ret),
    .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
    .rdata(rdata), .illegal(illegal), .trap_take(trap_take),
    .trap_vec(trap_vec), .epc(epc)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (architectural state as plain words) ----------------
  logic        m_mie, m_mpie;
  logic [31:0] m_ien, m_mip, m_mtvec, m_scr, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  function automatic logic [31:0] m_rd(input logic [11:0] a, output bit mapped);
    logic [31:0] v;
    mapped = 1'b1;
    v = 32'h0;
    case (a)
      12'h300: v = (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h304: v = m_ien;
      12'h305: v = m_mtvec;
      12'h340: v = m_scr;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: v = m_mip;
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      12'hF14: v = HID;
      default: mapped = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic m_ill(input bit mapped);
    return ((csr_rd || csr_wr) && !mapped) ||
           (csr_wr && (csr_addr == 12'h344 || csr_addr == 12'hF14));
  endfunction

  function automatic logic [3:0] m_code();
    logic [31:0] p;
    p = m_mip & m_ien;
    if (p[11]) return 4'd11;
    if (p[3])  return 4'd3;
    return 4'd7;
  endfunction

  function automatic logic m_irq();
    return m_mie && ((m_mip & m_ien) != 32'h0);
  endfunction

  task automatic model_check(input string tag);
    bit mapped;
    logic [31:0] v, tv;
    v  = m_rd(csr_addr, mapped);
    tv = m_mtvec & 32'hFFFF_FFFC;
`ifdef CSR_VECTORED_EN
    if (!exc_valid && m_irq() && m_mtvec[1:0] == 2'b01) tv = tv + 4 * 32'(m_code());
`endif
    if (csr_rd) chk({tag, ".rdata"}, rdata, v);
    chk({tag, ".illegal"}, 32'(illegal), 32'(m_ill(mapped)));
    chk({tag, ".trap_take"}, 32'(trap_take), 32'(exc_valid || m_irq()));
    chk({tag, ".trap_vec"}, trap_vec, tv);
    chk({tag, ".epc"}, epc, m_mepc);
  endtask

  task automatic model_update();
    bit mapped;
    logic [31:0] old, nv;
    logic trap, wok;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_ien = 0; m_mip = 0; m_mtvec = RV;
      m_scr = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
      return;
    end
    old  = m_rd(csr_addr, mapped);
    trap = exc_valid || m_irq();
    case (csr_op)
      2'd0:    nv = csr_wdata;
      2'd1:    nv = old | csr_wdata;
      2'd2:    nv = old & ~csr_wdata;
      default: nv = old;
    endcase
    wok = csr_wr && !m_ill(mapped) && csr_op != 2'd3 && !trap && !mret;
    if (wok && csr_addr == 12'hB00)      m_cyc[31:0]  = nv;
    else if (wok && csr_addr == 12'hB80) m_cyc[63:32] = nv;
    else                                 m_cyc = m_cyc + 1;
    if (wok && csr_addr == 12'hB02)      m_ins[31:0]  = nv;
    else if (wok && csr_addr == 12'hB82) m_ins[63:32] = nv;
    else if (inst_ret)                   m_ins = m_ins + 1;
    if (trap) begin
      m_mepc   = pc & 32'hFFFF_FFFC;
      m_mcause = exc_valid ? {28'h0, exc_cause} : {1'b1, 27'h0, m_code()};
      m_mpie   = m_mie;
      m_mie    = 1'b0;
    end else if (mret) begin
      m_mie  = m_mpie;
      m_mpie = 1'b1;
    end else if (wok) begin
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_ien = nv & 32'h888;
`ifdef CSR_VECTORED_EN
        12'h305: m_mtvec = (nv & 32'hFFFF_FFFC) | ((nv[1:0] == 2'b01) ? 32'h1 : 32'h0);
`else
        12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
`endif
        12'h340: m_scr = nv;
        12'h341: m_mepc = nv & 32'hFFFF_FFFC;
        12'h342: m_mcause = nv;
        default: ;
      endcase
    end
    m_mip = (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) | (irq_sw ? 32'h8 : 32'h0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clk_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic settle(input string tag);
    #2;
    model_check(tag);
  endtask

  task automatic idle();
    csr_rd = 0; csr_wr = 0; csr_addr = 12'h0; csr_wdata = 32'h0; csr_op = 2'd0;
    exc_valid = 0; exc_cause = 4'd0; mret = 0; inst_ret = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    idle(); csr_wr = 1; csr_addr = a; csr_op = op; csr_wdata = d;
    settle("wr");
    clk_step();
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    idle(); csr_rd = 1; csr_addr = a;
    settle(name);
    chk(name, rdata, exp);
    clk_step();
  endtask

  typedef struct {
    logic [11:0] a;
    logic [1:0]  op;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        wi;
    logic        ri;
  } vec_t;

  vec_t tbl[$];
  logic [11:0] addrs[14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                             12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h343};

  initial begin
    idle(); rst = 1; pc = 32'h0; irq_ext = 0; irq_sw = 0; irq_timer = 0;
    clk_step(); clk_step();
    rst = 0;

    // reset state
    idle(); csr_rd = 1; csr_addr = 12'h305;
    settle("rst");
    chk("rst.mtvec", rdata, RV);
    chk("rst.trap_take", 32'(trap_take), 32'h0);
    chk("rst.epc", epc, 32'h0);
    chk("rst.trap_vec", trap_vec, RV);
    clk_step();
    rd_chk("rst.mstatus", 12'h300, 32'h0);
    rd_chk("rst.mhartid", 12'hF14, 32'(HID));

    // table: write (check illegal), then read back
    tbl.push_back('{12'h340, 2'd0, 32'hF0F0_0000, 32'hF0F0_0000, 1'b0, 1'b0});
    tbl.push_back('{12'h340, 2'd1, 32'h0000_00FF, 32'hF0F0_00FF, 1'b0, 1'b0});
    tbl.push_back('{12'h340, 2'd2, 32'hF000_000F, 32'h00F0_00F0, 1'b0, 1'b0});
    tbl.push_back('{12'h340, 2'd3, 32'hFFFF_FFFF, 32'h00F0_00F0, 1'b0, 1'b0});
    tbl.push_back('{12'h341, 2'd0, 32'h1234_5677, 32'h1234_5674, 1'b0, 1'b0});
    tbl.push_back('{12'h342, 2'd0, 32'h8000_000B, 32'h8000_000B, 1'b0, 1'b0});
    tbl.push_back('{12'h304, 2'd0, 32'hFFFF_FFFF, 32'h0000_0888, 1'b0, 1'b0});
    tbl.push_back('{12'h304, 2'd2, 32'h0000_0080, 32'h0000_0808, 1'b0, 1'b0});
    tbl.push_back('{12'h300, 2'd0, 32'hFFFF_FFFF, 32'h0000_0088, 1'b0, 1'b0});
    tbl.push_back('{12'h300, 2'd2, 32'h0000_0088, 32'h0000_0000, 1'b0, 1'b0});
    tbl.push_back('{12'h305, 2'd0, 32'h0000_0203, 32'h0000_0200, 1'b0, 1'b0});
    tbl.push_back('{12'h344, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0});
    tbl.push_back('{12'hF14, 2'd1, 32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 1'b0});
    tbl.push_back('{12'h7C0, 2'd0, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1});
    tbl.push_back('{12'hB82, 2'd0, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0});
    tbl.push_back('{12'hB02, 2'd0, 32'h0000_0009, 32'h0000_0009, 1'b0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      idle(); csr_wr = 1; csr_addr = tbl[i].a; csr_op = tbl[i].op; csr_wdata = tbl[i].wd;
      settle("tbl.w");
      chk($sformatf("tbl%0d.wr_illegal", i), 32'(illegal), 32'(tbl[i].wi));
      clk_step();
      idle(); csr_rd = 1; csr_addr = tbl[i].a;
      settle("tbl.r");
      chk($sformatf("tbl%0d.rdata", i), rdata, tbl[i].rd);
      chk($sformatf("tbl%0d.rd_illegal", i), 32'(illegal), 32'(tbl[i].ri));
      clk_step();
    end

    // exception with a simultaneous mscratch write
    wr(12'h340, 2'd0, 32'hAAAA_5555);
    wr(12'h300, 2'd0, 32'h0000_0008);
    idle(); exc_valid = 1; exc_cause = 4'd2; pc = 32'h100;
    csr_wr = 1; csr_addr = 12'h340; csr_wdata = 32'h1234;
    settle("exc");
    chk("exc.trap_take", 32'(trap_take), 32'h1);
    chk("exc.trap_vec", trap_vec, 32'h200);
    clk_step();
    idle(); csr_rd = 1; csr_addr = 12'h342;
    settle("exc.after");
    chk("exc.mepc", epc, 32'h100);
    chk("exc.mcause", rdata, 32'h2);
    clk_step();
    rd_chk("exc.mstatus", 12'h300, 32'h80);
    rd_chk("exc.mscratch", 12'h340, 32'hAAAA_5555);

    // simultaneous ext + timer interrupt, then mret
    wr(12'h304, 2'd0, 32'h888);
    wr(12'h300, 2'd0, 32'h8);
    idle(); irq_timer = 1; irq_ext = 1; pc = 32'h200;
    settle("irq.n");
    chk("irq.n_trap", 32'(trap_take), 32'h0);
    clk_step();
    idle(); pc = 32'h204;
    settle("irq.n1");
    chk("irq.n1_trap", 32'(trap_take), 32'h1);
    clk_step();
    irq_timer = 0; irq_ext = 0;
    idle(); csr_rd = 1; csr_addr = 12'h342;
    settle("irq.cause");
    chk("irq.mcause", rdata, 32'h8000_000B);
    chk("irq.mepc", epc, 32'h204);
    clk_step();
    rd_chk("irq.mstatus", 12'h300, 32'h80);
    idle(); mret = 1;
    settle("mret");
    chk("mret.trap_take", 32'(trap_take), 32'h0);
    clk_step();
    rd_chk("mret.mstatus", 12'h300, 32'h88);

    // reset wins over a simultaneous exception
    idle(); rst = 1; exc_valid = 1; exc_cause = 4'd5; pc = 32'h444;
    clk_step();
    rst = 0;
    idle();
    settle("rstexc");
    chk("rstexc.epc", epc, 32'h0);
    clk_step();
    rd_chk("rstexc.mcause", 12'h342, 32'h0);

    // mcycle wrap
    wr(12'hB00, 2'd0, 32'hFFFF_FFFF);
    wr(12'hB80, 2'd0, 32'hFFFF_FFFF);
    rd_chk("wrap.hi_m1", 12'hB80, 32'hFFFF_FFFF);
    rd_chk("wrap.lo_m2", 12'hB00, 32'h0);
    rd_chk("wrap.hi_m3", 12'hB80, 32'h0);

    // timer interrupt with mtvec=0x201, then MIE write latency
    wr(12'h305, 2'd0, 32'h201);
    wr(12'h304, 2'd0, 32'h80);
    wr(12'h300, 2'd0, 32'h8);
    idle(); irq_timer = 1;
    settle("vec.n");
    clk_step();
    idle();
    settle("vec.n1");
    chk("vec.trap_take", 32'(trap_take), 32'h1);
`ifdef CSR_VECTORED_EN
    chk("vec.trap_vec", trap_vec, 32'h21C);
`else
    chk("vec.trap_vec", trap_vec, 32'h200);
`endif
    clk_step();
    rd_chk("vec.mcause", 12'h342, 32'h8000_0007);
    idle(); csr_wr = 1; csr_addr = 12'h300; csr_op = 2'd1; csr_wdata = 32'h8;
    settle("mie.n");
    chk("mie.n_trap", 32'(trap_take), 32'h0);
    clk_step();
    idle();
    settle("mie.n1");
    chk("mie.n1_trap", 32'(trap_take), 32'h1);
    clk_step();
    irq_timer = 0;
    idle(); rst = 1;
    clk_step();
    rst = 0;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      idle();
      rst       = ($urandom_range(0, 63) == 0);
      csr_addr  = addrs[$urandom_range(0, 13)];
      csr_rd    = ($urandom_range(0, 1) == 1);
      csr_wr    = ($urandom_range(0, 2) == 0);
      csr_op    = 2'($urandom_range(0, 3));
      csr_wdata = $urandom();
      pc        = $urandom();
      exc_valid = ($urandom_range(0, 15) == 0);
      exc_cause = 4'($urandom_range(0, 15));
      mret      = ($urandom_range(0, 11) == 0);
      inst_ret  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 5) == 0) irq_ext   = ~irq_ext;
      if ($urandom_range(0, 5) == 0) irq_sw    = ~irq_sw;
      if ($urandom_range(0, 5) == 0) irq_timer = ~irq_timer;
      settle("rnd");
      clk_step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
